// File: rtl/rom_dl_ctrl_if.sv
// rom_dl_ctrl_if: download-stream bundle between hps_io, the sequencer and the
// core's ROM/PROM download port.
//   ioctl_download  download-in-progress level from hps_io
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      25-bit byte address
//   ioctl_dout      byte data
//   dn_addr         registered write address to core
//   dn_data         registered write data to core
//   dn_wr           registered write strobe to core
//   dn_region       one-hot target of dn_wr: [0] main, [1] sound, [2] gfx, [3] prom
// master: the side that sources ioctl and observes dn (hps_io / bench).
// slave:  the download sequencer.
interface rom_dl_ctrl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [3:0]  dn_region;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, dn_region
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, dn_region
    );
endinterface

// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl: download sequencer between the hps_io ioctl stream and the
// arcade core's ROM/PROM download port. Forwards strictly sequential bytes,
// decodes the target region, keeps a byte count and 16-bit checksum, and
// holds the core in reset until a complete image has loaded plus a settle
// delay.
//   clk_sys     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   dl          ioctl input / dn output bundle (slave modport)
//   rst_req     synchronous OSD/button reset request, active-high
//   core_reset  registered active-high core reset
//   dl_done     last download completed correctly
//   dl_error    last download failed (sticky until next download)
//   byte_count  bytes accepted in current/last download
//   checksum    modulo-2^16 sum of accepted bytes
module rom_dl_ctrl #(
    parameter int unsigned IMAGE_SIZE = 26656,
    parameter logic [15:0] SND_BASE   = 16'h4000,
    parameter logic [15:0] GFX_BASE   = 16'h5800,
    parameter logic [15:0] PROM_BASE  = 16'h6800,
    parameter int unsigned RST_HOLD   = 16
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    rom_dl_ctrl_if.slave dl,
    input  logic         rst_req,
    output logic         core_reset,
    output logic         dl_done,
    output logic         dl_error,
    output logic [15:0]  byte_count,
    output logic [15:0]  checksum
);

    localparam logic [15:0] ImageSizeW = 16'(IMAGE_SIZE);
    localparam logic [7:0]  RstHoldW   = 8'(RST_HOLD);

    typedef enum logic [2:0] {StBoot, StLoad, StHold, StRun, StErr} state_e;

    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        load_err_q, load_err_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic [15:0] checksum_q, checksum_d;
    logic        dl_done_q, dl_done_d;
    logic        dl_error_q, dl_error_d;
    logic        core_reset_q;
    logic [15:0] dn_addr_q;
    logic [7:0]  dn_data_q;
    logic        dn_wr_q;
    logic [3:0]  dn_region_q;

    logic        strobe;
    logic        accept;
    logic        reject;
    logic [3:0]  region;

    // A strobe only counts while the level is still high and we are loading;
    // a strobe coincident with download falling is dropped.
    assign strobe = (state_q == StLoad) && dl.ioctl_download && dl.ioctl_wr;
    assign accept = strobe && (dl.ioctl_addr[24:16] == 9'd0)
                    && (dl.ioctl_addr[15:0] == byte_count_q)
                    && (byte_count_q < ImageSizeW);
    assign reject = strobe && !accept;

    always_comb begin
        region = 4'b1000;
        if (dl.ioctl_addr[15:0] < SND_BASE) begin
            region = 4'b0001;
        end else if (dl.ioctl_addr[15:0] < GFX_BASE) begin
            region = 4'b0010;
        end else if (dl.ioctl_addr[15:0] < PROM_BASE) begin
            region = 4'b0100;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        load_err_d   = load_err_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        dl_done_d    = dl_done_q;
        dl_error_d   = dl_error_q;

        unique case (state_q)
            StLoad: begin
                if (!dl.ioctl_download) begin
                    if ((byte_count_q == ImageSizeW) && !load_err_q) begin
                        state_d    = StHold;
                        hold_cnt_d = RstHoldW;
                    end else begin
                        state_d    = StErr;
                        dl_error_d = 1'b1;
                    end
                end else begin
                    if (accept) begin
                        byte_count_d = byte_count_q + 16'd1;
                        checksum_d   = checksum_q + {8'h00, dl.ioctl_dout};
                    end
                    if (reject) begin
                        load_err_d = 1'b1;
                    end
                end
            end
            StHold: begin
                // RUN is entered on the edge where the count reaches zero, so
                // the core spends exactly RST_HOLD cycles in HOLD.
                hold_cnt_d = hold_cnt_q - 8'd1;
                if (hold_cnt_q <= 8'd1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Set from the registered RUN state so it rises together with
                // the registered core_reset release.
                dl_done_d = 1'b1;
            end
            StBoot, StErr: begin
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        // A new download preempts every other state and starts from scratch.
        if ((state_q != StLoad) && dl.ioctl_download) begin
            state_d      = StLoad;
            byte_count_d = 16'd0;
            checksum_d   = 16'd0;
            load_err_d   = 1'b0;
            dl_done_d    = 1'b0;
            dl_error_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StBoot;
            hold_cnt_q   <= 8'd0;
            load_err_q   <= 1'b0;
            byte_count_q <= 16'd0;
            checksum_q   <= 16'd0;
            dl_done_q    <= 1'b0;
            dl_error_q   <= 1'b0;
            core_reset_q <= 1'b1;
            dn_addr_q    <= 16'd0;
            dn_data_q    <= 8'd0;
            dn_wr_q      <= 1'b0;
            dn_region_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            load_err_q   <= load_err_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            dl_done_q    <= dl_done_d;
            dl_error_q   <= dl_error_d;
            core_reset_q <= (state_q != StRun) | rst_req;
            dn_wr_q      <= accept;
            dn_region_q  <= accept ? region : 4'd0;
            if (accept) begin
                dn_addr_q <= dl.ioctl_addr[15:0];
                dn_data_q <= dl.ioctl_dout;
            end
        end
    end

    assign dl.dn_addr   = dn_addr_q;
    assign dl.dn_data   = dn_data_q;
    assign dl.dn_wr     = dn_wr_q;
    assign dl.dn_region = dn_region_q;
    assign core_reset   = core_reset_q;
    assign dl_done      = dl_done_q;
    assign dl_error     = dl_error_q;
    assign byte_count   = byte_count_q;
    assign checksum     = checksum_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb_rom_dl_ctrl: scoreboard bench for rom_dl_ctrl. Every accepted byte is
// predicted when driven and checked against the dn port when it appears.
`timescale 1ns/1ps
module tb_rom_dl_ctrl;

    localparam int unsigned IMAGE_SIZE = 26656;
    localparam int unsigned RST_HOLD   = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [3:0]  region;
    } beat_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        rst_req;
    logic        core_reset;
    logic        dl_done;
    logic        dl_error;
    logic [15:0] byte_count;
    logic [15:0] checksum;

    rom_dl_ctrl_if dl_if ();

    rom_dl_ctrl #(
        .IMAGE_SIZE (IMAGE_SIZE),
        .SND_BASE   (16'h4000),
        .GFX_BASE   (16'h5800),
        .PROM_BASE  (16'h6800),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl         (dl_if),
        .rst_req    (rst_req),
        .core_reset (core_reset),
        .dl_done    (dl_done),
        .dl_error   (dl_error),
        .byte_count (byte_count),
        .checksum   (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_beats = 0;
    beat_t       sb[$];
    beat_t       mon_exp;
    int unsigned m_count;
    logic [15:0] m_sum;
    bit          m_err;

    function automatic logic [3:0] exp_region(input logic [15:0] a);
        if (a < 16'h4000) return 4'b0001;
        if (a < 16'h5800) return 4'b0010;
        if (a < 16'h6800) return 4'b0100;
        return 4'b1000;
    endfunction

    // dn port monitor: pops one prediction per dn_wr pulse.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            n_total++;
            if (dl_if.dn_wr) begin
                n_beats++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_dn_wr: got addr %h data %h region %b, want no write",
                             dl_if.dn_addr, dl_if.dn_data, dl_if.dn_region);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({dl_if.dn_addr, dl_if.dn_data, dl_if.dn_region} !== mon_exp) begin
                        $display("FAIL dn_beat: got %h/%h/%b want %h/%h/%b",
                                 dl_if.dn_addr, dl_if.dn_data, dl_if.dn_region,
                                 mon_exp.addr, mon_exp.data, mon_exp.region);
                    end else begin
                        n_pass++;
                    end
                end
            end else if (dl_if.dn_region !== 4'b0000) begin
                $display("FAIL dn_region_idle: got %b want 0000", dl_if.dn_region);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic start_dl();
        @(posedge clk_sys); #1;
        dl_if.ioctl_wr       = 1'b0;
        dl_if.ioctl_download = 1'b1;
        m_count = 0;
        m_sum   = 16'h0000;
        m_err   = 1'b0;
    endtask

    task automatic end_dl();
        @(posedge clk_sys); #1;
        dl_if.ioctl_wr       = 1'b0;
        dl_if.ioctl_download = 1'b0;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d, input int idle);
        @(posedge clk_sys); #1;
        dl_if.ioctl_wr   = 1'b1;
        dl_if.ioctl_addr = a;
        dl_if.ioctl_dout = d;
        if ((a[24:16] == 9'd0) && (a[15:0] == m_count[15:0]) && (m_count < IMAGE_SIZE)) begin
            sb.push_back('{addr: a[15:0], data: d, region: exp_region(a[15:0])});
            m_count++;
            m_sum = m_sum + {8'h00, d};
        end else begin
            m_err = 1'b1;
        end
        repeat (idle) begin
            @(posedge clk_sys); #1;
            dl_if.ioctl_wr = 1'b0;
        end
    endtask

    task automatic check_sb_empty(input string name);
        n_total++;
        if (sb.size() !== 0) $display("FAIL %s_sb_empty: got %0d pending want 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n              = 1'b0;
        rst_req              = 1'b0;
        dl_if.ioctl_download = 1'b0;
        dl_if.ioctl_wr       = 1'b0;
        dl_if.ioctl_addr     = '0;
        dl_if.ioctl_dout     = '0;
        repeat (3) @(negedge clk_sys);
        n_total++;
        if ({dl_if.dn_addr, dl_if.dn_data, dl_if.dn_wr, dl_if.dn_region} !== 29'd0)
            $display("FAIL reset_dn_bus: got %h want 0",
                     {dl_if.dn_addr, dl_if.dn_data, dl_if.dn_wr, dl_if.dn_region});
        else n_pass++;
        n_total++;
        if ({core_reset, dl_done, dl_error} !== 3'b100)
            $display("FAIL reset_flags: got %b want 100", {core_reset, dl_done, dl_error});
        else n_pass++;
        n_total++;
        if ({byte_count, checksum} !== 32'd0)
            $display("FAIL reset_counts: got %h want 0", {byte_count, checksum});
        else n_pass++;
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        n_total++;
        if (core_reset !== 1'b1) $display("FAIL boot_core_reset: got %b want 1", core_reset);
        else n_pass++;
    endtask

    task automatic test_short_image();
        start_dl();
        for (int i = 0; i < 'h6000; i++) send(25'(i), 8'(i), 0);
        end_dl();
        repeat (RST_HOLD + 4) @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if ({core_reset, dl_done, dl_error} !== {1'b1, 1'b0, 1'b1})
            $display("FAIL short_flags: got %b want 101", {core_reset, dl_done, dl_error});
        else n_pass++;
        n_total++;
        if (byte_count !== 16'h6000) $display("FAIL short_count: got %h want 6000", byte_count);
        else n_pass++;
        n_total++;
        if (checksum !== m_sum) $display("FAIL short_checksum: got %h want %h", checksum, m_sum);
        else n_pass++;
        check_sb_empty("short");
    endtask

    task automatic test_full_image();
        int beats0;
        beats0 = n_beats;
        start_dl();
        for (int i = 0; i < int'(IMAGE_SIZE); i++) begin
            send(25'(i), 8'(i), (i < 1024) ? 3 : 0);
            if (i == 16) begin
                @(negedge clk_sys);
                n_total++;
                if ({dl_done, dl_error} !== 2'b00)
                    $display("FAIL full_flags_cleared: got %b want 00", {dl_done, dl_error});
                else n_pass++;
            end
        end
        end_dl();
        repeat (RST_HOLD + 1) @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if ({core_reset, dl_done} !== 2'b10)
            $display("FAIL full_hold_end: got %b want 10", {core_reset, dl_done});
        else n_pass++;
        @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if ({core_reset, dl_done, dl_error} !== 3'b010)
            $display("FAIL full_release: got %b want 010", {core_reset, dl_done, dl_error});
        else n_pass++;
        n_total++;
        if (byte_count !== 16'(IMAGE_SIZE))
            $display("FAIL full_count: got %h want %h", byte_count, 16'(IMAGE_SIZE));
        else n_pass++;
        n_total++;
        if (checksum !== m_sum) $display("FAIL full_checksum: got %h want %h", checksum, m_sum);
        else n_pass++;
        n_total++;
        if (n_beats - beats0 !== int'(IMAGE_SIZE))
            $display("FAIL full_beats: got %0d want %0d", n_beats - beats0, IMAGE_SIZE);
        else n_pass++;
        check_sb_empty("full");
    endtask

    task automatic test_rst_req();
        @(posedge clk_sys); #1;
        rst_req = 1'b1;
        @(negedge clk_sys);
        n_total++;
        if (core_reset !== 1'b0) $display("FAIL rst_req_lat_rise: got %b want 0", core_reset);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk_sys); #1;
            if (k == 3) rst_req = 1'b0;
            @(negedge clk_sys);
            n_total++;
            if (core_reset !== 1'b1) $display("FAIL rst_req_high_%0d: got %b want 1", k, core_reset);
            else n_pass++;
        end
        @(negedge clk_sys);
        n_total++;
        if (core_reset !== 1'b0) $display("FAIL rst_req_fall: got %b want 0", core_reset);
        else n_pass++;
        n_total++;
        if ({byte_count, checksum, dl_done} !== {m_count[15:0], m_sum, 1'b1})
            $display("FAIL rst_req_state: got %h/%h/%b want %h/%h/1",
                     byte_count, checksum, dl_done, m_count[15:0], m_sum);
        else n_pass++;
    endtask

    task automatic test_skip();
        start_dl();
        for (int i = 0; i < 'hFF; i++) send(25'(i), 8'(i), 0);
        send({9'h001, 16'h00FF}, 8'hAA, 0);
        send(25'h0_0100, 8'h55, 0);
        @(posedge clk_sys); #1;
        dl_if.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        n_total++;
        if (dl_if.dn_wr !== 1'b0) $display("FAIL skip_no_wr: got %b want 0", dl_if.dn_wr);
        else n_pass++;
        n_total++;
        if (byte_count !== 16'h00FF) $display("FAIL skip_count: got %h want 00ff", byte_count);
        else n_pass++;
        end_dl();
        repeat (RST_HOLD + 4) @(posedge clk_sys);
        @(negedge clk_sys);
        n_total++;
        if ({core_reset, dl_done, dl_error} !== {1'b1, 1'b0, m_err || (m_count != IMAGE_SIZE)})
            $display("FAIL skip_flags: got %b want 101", {core_reset, dl_done, dl_error});
        else n_pass++;
        n_total++;
        if ({byte_count, checksum} !== {m_count[15:0], m_sum})
            $display("FAIL skip_counts: got %h/%h want %h/%h",
                     byte_count, checksum, m_count[15:0], m_sum);
        else n_pass++;
        check_sb_empty("skip");
    endtask

    task automatic test_reset_mid_load();
        start_dl();
        for (int i = 0; i < 'h1000; i++) send(25'(i), 8'(i), 0);
        @(posedge clk_sys); #1;
        dl_if.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        n_total++;
        if (byte_count !== 16'h1000) $display("FAIL midload_count: got %h want 1000", byte_count);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({dl_if.dn_addr, dl_if.dn_data, dl_if.dn_wr, dl_if.dn_region} !== 29'd0)
            $display("FAIL midload_dn_bus: got %h want 0",
                     {dl_if.dn_addr, dl_if.dn_data, dl_if.dn_wr, dl_if.dn_region});
        else n_pass++;
        n_total++;
        if ({core_reset, dl_done, dl_error, byte_count, checksum} !== {3'b100, 32'd0})
            $display("FAIL midload_state: got %h want %h",
                     {core_reset, dl_done, dl_error, byte_count, checksum}, {3'b100, 32'd0});
        else n_pass++;
        dl_if.ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        n_total++;
        if ({core_reset, dl_done, dl_error, byte_count} !== {3'b100, 16'd0})
            $display("FAIL midload_boot: got %h want %h",
                     {core_reset, dl_done, dl_error, byte_count}, {3'b100, 16'd0});
        else n_pass++;
        check_sb_empty("midload");
    endtask

    initial begin
        test_reset();
        test_short_image();
        test_full_image();
        test_rst_req();
        test_skip();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
